// File: rtl/int_regs_wb_arb.sv
// int_regs_wb_arb: integer register-file write-port arbiter with per-source FIFOs and a
// pending-write scoreboard. Define WB_ARB_RR_EN for round-robin ties; otherwise s1 wins ties.

module int_regs_wb_arb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [4:0]  push_addr,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic        ready,
    output logic        not_empty,
    output logic [4:0]  head_addr,
    output logic [31:0] head_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // NOTE: entry storage has no reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Ready comes from the registered count only, so it never depends on valid.
    assign ready     = (count < FULL_COUNT);
    assign not_empty = (count != '0);
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];
endmodule

module int_regs_wb_arb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [4:0]  s0_rd_addr,
    input  logic [31:0] s0_wdata,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [4:0]  s1_rd_addr,
    input  logic [31:0] s1_wdata,
    input  logic        claim_en,
    input  logic [4:0]  claim_addr,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        wen,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic        idle
);
    logic        s0_push;
    logic        s1_push;
    logic        s0_ne;
    logic        s1_ne;
    logic        grant0;
    logic        grant1;
    logic [4:0]  s0_head_addr;
    logic [4:0]  s1_head_addr;
    logic [31:0] s0_head_data;
    logic [31:0] s1_head_data;
    logic [31:1] busy_q;
    logic [31:1] busy_next;
    logic [31:0] busy_vec;

    // Writes to x0 complete the handshake but never occupy a FIFO slot.
    assign s0_push = s0_valid && s0_ready && (s0_rd_addr != 5'd0);
    assign s1_push = s1_valid && s1_ready && (s1_rd_addr != 5'd0);

    int_regs_wb_arb_fifo #(.DEPTH(DEPTH)) u_s0_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s0_push),
        .push_addr (s0_rd_addr),
        .push_data (s0_wdata),
        .pop       (grant0),
        .ready     (s0_ready),
        .not_empty (s0_ne),
        .head_addr (s0_head_addr),
        .head_data (s0_head_data)
    );

    int_regs_wb_arb_fifo #(.DEPTH(DEPTH)) u_s1_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_push),
        .push_addr (s1_rd_addr),
        .push_data (s1_wdata),
        .pop       (grant1),
        .ready     (s1_ready),
        .not_empty (s1_ne),
        .head_addr (s1_head_addr),
        .head_data (s1_head_data)
    );

`ifdef WB_ARB_RR_EN
    // Set when s1 received the most recent grant; reset value lets s0 win the first tie.
    logic last_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_s1 <= 1'b1;
        end else if (grant0) begin
            last_s1 <= 1'b0;
        end else if (grant1) begin
            last_s1 <= 1'b1;
        end
    end
`endif

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (s0_ne && s1_ne) begin
`ifdef WB_ARB_RR_EN
            if (last_s1) grant0 = 1'b1;
            else         grant1 = 1'b1;
`else
            grant1 = 1'b1;
`endif
        end else if (s0_ne) begin
            grant0 = 1'b1;
        end else if (s1_ne) begin
            grant1 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen      <= 1'b0;
            rd_addr  <= 5'd0;
            rd_wdata <= 32'd0;
        end else begin
            wen <= grant0 || grant1;
            if (grant1) begin
                rd_addr  <= s1_head_addr;
                rd_wdata <= s1_head_data;
            end else if (grant0) begin
                rd_addr  <= s0_head_addr;
                rd_wdata <= s0_head_data;
            end
        end
    end

    // Clear on commit first, then apply the claim so a same-edge set wins.
    always_comb begin
        busy_next = busy_q;
        for (int i = 1; i < 32; i++) begin
            if (wen && (rd_addr == 5'(i)))         busy_next[i] = 1'b0;
            if (claim_en && (claim_addr == 5'(i))) busy_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_vec = {busy_q, 1'b0};
    assign rs1_busy = busy_vec[rs1_addr];
    assign rs2_busy = busy_vec[rs2_addr];
    assign idle     = !s0_ne && !s1_ne && !wen;
endmodule

// File: tb/tb_int_regs_wb_arb.sv
// Directed self-checking bench for int_regs_wb_arb (DEPTH = 2); expectations follow
// WB_ARB_RR_EN when it is defined for the build.

module tb_int_regs_wb_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s0_valid = 1'b0;
    logic        s0_ready;
    logic [4:0]  s0_rd_addr = 5'd0;
    logic [31:0] s0_wdata = 32'd0;
    logic        s1_valid = 1'b0;
    logic        s1_ready;
    logic [4:0]  s1_rd_addr = 5'd0;
    logic [31:0] s1_wdata = 32'd0;
    logic        claim_en = 1'b0;
    logic [4:0]  claim_addr = 5'd0;
    logic [4:0]  rs1_addr = 5'd0;
    logic [4:0]  rs2_addr = 5'd0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [4:0]  q_addr [$];
    logic [31:0] q_data [$];
    int          q_cyc  [$];

    int_regs_wb_arb #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s0_rd_addr (s0_rd_addr),
        .s0_wdata   (s0_wdata),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_rd_addr (s1_rd_addr),
        .s1_wdata   (s1_wdata),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .wen        (wen),
        .rd_addr    (rd_addr),
        .rd_wdata   (rd_wdata),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Commit log: every cycle with wen high is a register-file write at the next edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wen === 1'b1) begin
            q_addr.push_back(rd_addr);
            q_data.push_back(rd_wdata);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        @(posedge clk);
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        claim_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_s0(input logic [4:0] addrs [8], input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            @(negedge clk);
            s0_valid   = 1'b1;
            s0_rd_addr = addrs[i];
            s0_wdata   = 32'hA000_0000 | 32'(addrs[i]);
            while (!s0_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!s0_ready) begin
                checks++;
                errors++;
                $display("FAIL s0_handshake_timeout: ready=%0b required 1", s0_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        s0_valid = 1'b0;
    endtask

    task automatic drive_s1(input logic [4:0] addrs [8], input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            @(negedge clk);
            s1_valid   = 1'b1;
            s1_rd_addr = addrs[i];
            s1_wdata   = 32'hB000_0000 | 32'(addrs[i]);
            while (!s1_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!s1_ready) begin
                checks++;
                errors++;
                $display("FAIL s1_handshake_timeout: ready=%0b required 1", s1_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        s1_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic saw_wen;
        #3;
        checks++;
        if (wen !== 1'b0 || rd_addr !== 5'd0 || rd_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: wen=%0b addr=%0d data=%0h required 0/0/0", wen, rd_addr, rd_wdata);
        end
        checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_idle: s0r=%0b s1r=%0b idle=%0b required 1/1/1", s0_ready, s1_ready, idle);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Load both FIFOs, then pull reset asynchronously while entries are queued.
        @(negedge clk);
        s0_valid = 1'b1; s0_rd_addr = 5'd1; s0_wdata = 32'h11;
        s1_valid = 1'b1; s1_rd_addr = 5'd2; s1_wdata = 32'h22;
        claim_en = 1'b1; claim_addr = 5'd9; rs1_addr = 5'd9; rs2_addr = 5'd9;
        @(negedge clk);
        s0_rd_addr = 5'd3; s0_wdata = 32'h33;
        s1_rd_addr = 5'd4; s1_wdata = 32'h44;
        claim_en = 1'b0;
        @(negedge clk);
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        checks++;
        if (wen !== 1'b1 || rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL prereset_activity: wen=%0b busy9=%0b required 1/1", wen, rs1_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wen !== 1'b0 || rd_addr !== 5'd0 || rd_wdata !== 32'd0) begin
            errors++;
            $display("FAIL midreset_outputs: wen=%0b addr=%0d data=%0h required 0/0/0", wen, rd_addr, rd_wdata);
        end
        checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || s0_ready !== 1'b1 || s1_ready !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: busy=%0b/%0b ready=%0b/%0b idle=%0b required 0/0 1/1 1",
                     rs1_busy, rs2_busy, s0_ready, s1_ready, idle);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_wen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (wen !== 1'b0) saw_wen = 1'b1;
        end
        checks++;
        if (saw_wen !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL postreset_no_write: saw_wen=%0b idle=%0b required 0/1", saw_wen, idle);
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        claim_en = 1'b1; claim_addr = 5'd5; rs1_addr = 5'd5; rs2_addr = 5'd5;
        @(negedge clk);
        claim_en = 1'b0;
        checks++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
            errors++;
            $display("FAIL claim_sets_busy: rs1=%0b rs2=%0b required 1/1", rs1_busy, rs2_busy);
        end
        @(negedge clk);
        @(negedge clk);
        s0_valid = 1'b1; s0_rd_addr = 5'd5; s0_wdata = 32'hDEADBEEF;
        checks++;
        if (s0_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: s0_ready=%0b required 1", s0_ready);
        end
        @(negedge clk);
        s0_valid = 1'b0;
        checks++;
        if (wen !== 1'b0 || rs1_busy !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL single_grant_cycle: wen=%0b busy=%0b idle=%0b required 0/1/0", wen, rs1_busy, idle);
        end
        @(negedge clk);
        checks++;
        if (wen !== 1'b1 || rd_addr !== 5'd5 || rd_wdata !== 32'hDEADBEEF || rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_write_port: wen=%0b addr=%0d data=%0h busy=%0b required 1/5/deadbeef/1",
                     wen, rd_addr, rd_wdata, rs1_busy);
        end
        @(negedge clk);
        checks++;
        if (wen !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_commit_clear: wen=%0b busy=%0b/%0b idle=%0b required 0/0/0/1",
                     wen, rs1_busy, rs2_busy, idle);
        end
    endtask

    task automatic test_contention();
        logic [4:0] a0 [8];
        logic [4:0] a1 [8];
        logic [4:0] exp_a [6];
        logic       exp_s1 [6];
        a0 = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        a1 = '{5'd4, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
`ifdef WB_ARB_RR_EN
        exp_a  = '{5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6};
        exp_s1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_a  = '{5'd4, 5'd5, 5'd6, 5'd1, 5'd2, 5'd3};
        exp_s1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        apply_reset();
        clear_log();
        fork
            drive_s0(a0, 3);
            drive_s1(a1, 3);
        join
        repeat (4) @(negedge clk);
        @(posedge clk);
        checks++;
        if (q_addr.size() != 6) begin
            errors++;
            $display("FAIL contention_count: got %0d commits required 6", q_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                logic [31:0] exp_d;
                exp_d = (exp_s1[i] ? 32'hB000_0000 : 32'hA000_0000) | 32'(exp_a[i]);
                checks++;
                if (q_addr[i] !== exp_a[i] || q_data[i] !== exp_d || q_cyc[i] != q_cyc[0] + i) begin
                    errors++;
                    $display("FAIL contention_commit%0d: addr=%0d data=%0h cyc_off=%0d required %0d/%0h/%0d",
                             i, q_addr[i], q_data[i], q_cyc[i] - q_cyc[0], exp_a[i], exp_d, i);
                end
            end
        end
    endtask

    task automatic test_full_backpressure();
        logic [4:0] a0 [8];
        logic [4:0] a1 [8];
        logic [4:0] exp_a [9];
        a0 = '{5'd20, 5'd21, 5'd22, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        a1 = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd0};
`ifdef WB_ARB_RR_EN
        exp_a = '{5'd20, 5'd10, 5'd21, 5'd11, 5'd22, 5'd12, 5'd13, 5'd14, 5'd15};
`else
        exp_a = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd20, 5'd21, 5'd22};
`endif
        apply_reset();
        clear_log();
        fork
            drive_s0(a0, 3);
            drive_s1(a1, 6);
            begin
                repeat (3) @(negedge clk);
                checks++;
`ifdef WB_ARB_RR_EN
                if (s0_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_s0_not_full: s0_ready=%0b required 1", s0_ready);
                end
`else
                if (s0_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_after_two: s0_ready=%0b required 0", s0_ready);
                end
                repeat (5) @(negedge clk);
                checks++;
                if (s0_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_while_blocked: s0_ready=%0b required 0", s0_ready);
                end
                @(negedge clk);
                checks++;
                if (s0_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_pop: s0_ready=%0b required 1", s0_ready);
                end
`endif
            end
        join
        repeat (4) @(negedge clk);
        @(posedge clk);
        checks++;
        if (q_addr.size() != 9) begin
            errors++;
            $display("FAIL full_count: got %0d commits required 9", q_addr.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                logic [31:0] exp_d;
                exp_d = (exp_a[i] < 5'd20 ? 32'hB000_0000 : 32'hA000_0000) | 32'(exp_a[i]);
                checks++;
                if (q_addr[i] !== exp_a[i] || q_data[i] !== exp_d) begin
                    errors++;
                    $display("FAIL full_commit%0d: addr=%0d data=%0h required %0d/%0h",
                             i, q_addr[i], q_data[i], exp_a[i], exp_d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] a0 [8];
        a0 = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd0, 5'd0, 5'd0, 5'd0};
        apply_reset();
        clear_log();
        drive_s0(a0, 4);
        repeat (3) @(negedge clk);
        @(posedge clk);
        checks++;
        if (q_addr.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d commits required 4", q_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_addr[i] !== a0[i] || q_cyc[i] != q_cyc[0] + i) begin
                    errors++;
                    $display("FAIL b2b_commit%0d: addr=%0d cyc_off=%0d required %0d/%0d",
                             i, q_addr[i], q_cyc[i] - q_cyc[0], a0[i], i);
                end
            end
        end
    endtask

    task automatic test_corner_cases();
        apply_reset();
        clear_log();
        @(negedge clk);
        s0_valid = 1'b1; s0_rd_addr = 5'd0; s0_wdata = 32'h1234;
        checks++;
        if (s0_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: s0_ready=%0b required 1", s0_ready);
        end
        @(negedge clk);
        s0_valid = 1'b0;
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL x0_no_entry: idle=%0b required 1", idle);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        checks++;
        if (q_addr.size() != 0) begin
            errors++;
            $display("FAIL x0_no_wen: got %0d commits required 0", q_addr.size());
        end

        // Re-claim x7 on the very edge its write commits.
        @(negedge clk);
        claim_en = 1'b1; claim_addr = 5'd7; rs1_addr = 5'd7;
        @(negedge clk);
        claim_en = 1'b0;
        s0_valid = 1'b1; s0_rd_addr = 5'd7; s0_wdata = 32'h7777;
        @(negedge clk);
        s0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wen !== 1'b1 || rd_addr !== 5'd7) begin
            errors++;
            $display("FAIL x7_commit_cycle: wen=%0b addr=%0d required 1/7", wen, rd_addr);
        end
        claim_en = 1'b1; claim_addr = 5'd7;
        @(negedge clk);
        claim_en = 1'b0;
        checks++;
        if (rs1_busy !== 1'b1 || wen !== 1'b0) begin
            errors++;
            $display("FAIL claim_wins_clear: busy7=%0b wen=%0b required 1/0", rs1_busy, wen);
        end
        s0_valid = 1'b1; s0_rd_addr = 5'd7; s0_wdata = 32'h7778;
        @(negedge clk);
        s0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL x7_second_clear: busy7=%0b required 0", rs1_busy);
        end

        @(negedge clk);
        claim_en = 1'b1; claim_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        @(negedge clk);
        claim_en = 1'b0;
        checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL x0_claim_ignored: rs1=%0b rs2=%0b required 0/0", rs1_busy, rs2_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_full_backpressure();
        test_back_to_back();
        test_corner_cases();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_regs_wb_arb.md
# int_regs_wb_arb

Write-port arbiter and pending-write scoreboard for the integer register file. It takes register writebacks from two independent sources: s0, the ALU/execute path, and s1, the load/memory path. Each source has its own valid/ready handshake and is buffered in a per-source FIFO. The block drives the register file's single write port with at most one write per cycle. It also tracks which destination registers have writes outstanding, so issue logic can stall on read-after-write hazards.

## Interface
Parameters:
- DEPTH, 2, entries per source FIFO; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- s0_valid  in  1  ALU writeback request
- s0_ready  out  1  s0 FIFO can accept
- s0_rd_addr  in  5  destination register
- s0_wdata  in  32  write data
- s1_valid / s1_ready / s1_rd_addr / s1_wdata  same as s0, load path
- claim_en  in  1  issue stage marks claim_addr as pending
- claim_addr  in  5  destination being claimed
- rs1_addr, rs2_addr  in  5 each  hazard lookup addresses
- rs1_busy, rs2_busy  out  1 each  lookup register has a pending write
- wen  out  1  register-file write enable (registered)
- rd_addr  out  5  register-file write address (registered)
- rd_wdata  out  32  register-file write data (registered)
- idle  out  1  both FIFOs empty and wen low

## Operation
- **Handshake:** a transfer occurs on a rising edge where sN_valid && sN_ready.
  - sN_ready = FIFO count < DEPTH. It is derived from registered state only and never depends on sN_valid.
- **Writes to x0:** a transfer with rd_addr = 0 is accepted, consumes no FIFO entry and never reaches the write port.
- **Arbitration:** each cycle the arbiter considers only entries present at the start of the cycle.
  - If exactly one FIFO is non-empty, its head is popped.
  - If both are non-empty, the policy is set per Configuration.
  - The popped entry loads the output register. Otherwise wen = 0 next cycle, with rd_addr and rd_wdata holding their previous values.
- **Ordering:** FIFO order is preserved within a source. No ordering is guaranteed across sources; issue logic must not claim a register that is already busy.
- **Scoreboard:** busy[31:1] bits, and busy[0] is constantly 0.
  - claim_en sets busy[claim_addr] at the edge; a claim of x0 is ignored.
  - A commit edge (wen = 1 during the cycle) clears busy[rd_addr].
  - If a claim and a clear hit the same address on the same edge, the set wins.
- **Lookup:** rsN_busy = busy[rsN_addr], combinational from registered bits.
- **FIFO boundaries:** a push into a full FIFO cannot occur because ready is low. A simultaneous push and pop on a full FIFO is not allowed, since ready is already low at the start of that cycle. Pointers wrap modulo DEPTH.
- **Reset:** asserting rst_n at any time empties both FIFOs and discards in-flight data.
  - Outputs during and after reset: wen = 0, rd_addr = 0, rd_wdata = 0, all busy bits = 0, s0_ready = s1_ready = 1, idle = 1.
  - The round-robin pointer resets so that s0 wins the first tie.

## Timing
- Accept at edge k, with the FIFO previously empty and no contention:
  - the entry is granted during cycle k→k+1,
  - wen is high in cycle k+1→k+2,
  - the register file writes at edge k+2.
- Minimum accept-to-commit latency is therefore 2 edges.
- Sustained throughput is one write per cycle across both sources combined.
- A back-to-back stream from a single source with DEPTH ≥ 2 runs with no bubbles.
- busy clears on the same edge the register file captures the data, so a reader that sees busy = 0 reads the new value combinationally.

## Configuration
- **WB_ARB_RR_EN defined:** round-robin arbitration.
  - On a tie, grant the source not granted most recently.
  - A single-source grant also updates the pointer.
  - Neither source starves; with both FIFOs continuously non-empty, grants alternate s0, s1, s0, …
- **WB_ARB_RR_EN undefined:** fixed priority, s1 (load) over s0 on every tie.
  - No pointer register is built.
  - s0 can starve under continuous s1 traffic.

## Test plan
- **Reset values:** drive rst_n low mid-stream with both FIFOs holding entries. Required: wen = 0 immediately, all busy = 0, both ready = 1, idle = 1; no write appears after release.
- **Single write and scoreboard:** claim x5; 3 cycles later push s0 (x5, 0xDEADBEEF). Required: rs1_busy(x5) = 1 until the commit edge; wen high exactly 2 edges after accept with rd_addr = 5 and data 0xDEADBEEF; busy clears at that same edge.
- **Contention with WB_ARB_RR_EN:** preload s0 with x1–x3 and s1 with x4–x6. Required: commit order x1, x4, x2, x5, x3, x6.
- **Contention without WB_ARB_RR_EN:** same preload. Required: commit order x4, x5, x6, x1, x2, x3.
- **Full and backpressure:** with DEPTH = 2, push 3 entries on s0 while the output is blocked by continuous s1 priority. Required: s0_ready = 0 after 2 accepts; the third is accepted only after the first s0 pop; no entry is lost or duplicated.
- **Corner cases:**
  - A push to x0 produces no wen.
  - A claim and a commit of x7 on the same edge leave busy[7] = 1.
  - A claim of x0 leaves rs1_busy(x0) = 0.
